// File: rtl/mux_rr_arbiter_8.sv
// mux_rr_arbiter_8
// Round-robin arbiter and sequencer for an 8:1 data mux. Eight requesters each
// present a word; one is granted at a time. The winning word is captured into
// an output register, offered downstream on a valid/ready handshake, and the
// winner is acknowledged when the word is accepted.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   req        req[i]=1: requester i has a word on d<i>
//   d0..d7     requester data words
//   out_data   registered winning word
//   out_valid  out_data valid, held until accepted
//   out_ready  downstream accepts when out_valid & out_ready
//   sel        index of the current/last winner (mux select)
//   gnt        one-hot grant, nonzero only while holding a word
//   ack        one-hot, combinational: acceptance strobe for the granted requester
//   busy       1 while holding a word
module mux_rr_arbiter_8 #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  input  logic [width-1:0] d0,
  input  logic [width-1:0] d1,
  input  logic [width-1:0] d2,
  input  logic [width-1:0] d3,
  input  logic [width-1:0] d4,
  input  logic [width-1:0] d5,
  input  logic [width-1:0] d6,
  input  logic [width-1:0] d7,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       sel,
  output logic [7:0]       gnt,
  output logic [7:0]       ack,
  output logic             busy
);

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  state_e           state_q;
  logic [2:0]       last_q;
  logic [2:0]       sel_q;
  logic [7:0]       gnt_q;
  logic [width-1:0] out_data_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [width-1:0] data_arr [8];
  logic [2:0]       scan_idx;
  logic [2:0]       win;
  logic             win_found;

  always_comb begin
    data_arr[0] = d0;
    data_arr[1] = d1;
    data_arr[2] = d2;
    data_arr[3] = d3;
    data_arr[4] = d4;
    data_arr[5] = d5;
    data_arr[6] = d6;
    data_arr[7] = d7;
  end

  // Scan last+1, last+2, ... (3-bit wrap) and take the first active request.
  // Offset 8 wraps back to last itself, so a lone repeat requester still wins.
  always_comb begin
    win       = last_q;
    win_found = 1'b0;
    scan_idx  = last_q;
    for (int unsigned off = 1; off <= 8; off++) begin
      scan_idx = last_q + off[2:0];
      if (!win_found && req[scan_idx]) begin
        win       = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Single-process FSM with registered outputs. The pointer only advances on
  // acceptance, so a grant abandoned by reset never counts as served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 3'd7;
      sel_q       <= 3'd0;
      gnt_q       <= 8'h00;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            sel_q       <= win;
            gnt_q       <= 8'h01 << win;
            out_data_q  <= data_arr[win];
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StHold;
          end else begin
            out_valid_q <= 1'b0;
            gnt_q       <= 8'h00;
            busy_q      <= 1'b0;
          end
        end
        StHold: begin
          // Everything stays frozen until the word is taken, whatever req/d do.
          if (out_ready) begin
            last_q      <= sel_q;
            out_valid_q <= 1'b0;
            gnt_q       <= 8'h00;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A reset cycle abandons the held word, so it must not be acknowledged.
  assign ack       = gnt_q & {8{out_valid_q & out_ready & ~rst}};
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;

endmodule
